// File: rtl/wb_timeout_reg.sv
// Registered Wishbone pass-through with a slave-response watchdog.
// A master request is captured into output registers and presented to the
// slave. The first slave response (err > rty > ack) is returned to the master
// one cycle later. A slave that stays silent for TIMEOUT strobe cycles is
// answered with an error, and the expiry is counted. TIMEOUT = 0 turns the
// watchdog off.
module wb_timeout_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 256,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // master side
    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    input  logic                    wbm_cyc_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    // slave side
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    // watchdog status
    output logic                    timeout_o,
    output logic [COUNT_WIDTH-1:0]  timeout_count_o
);

    // Handshake: a request is cyc & stb from the master. It is accepted only
    // in IDLE while no master response is pending. Once accepted, wbs_stb_o and
    // wbs_cyc_o stay high with stable address/data/we/sel until one of these
    // happens: the slave asserts ack/err/rty, the watchdog expires, or the
    // master drops cyc (abort). Exactly one master response is high for
    // exactly one cycle after a slave response or an expiry, and none after
    // an abort.

    // The timer counts down from TIMEOUT; its width covers that value.
    localparam int TIMER_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(TIMEOUT);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam bit WATCHDOG_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [TIMER_WIDTH-1:0]  timer;
    logic [TIMER_WIDTH-1:0]  timer_next;

    logic [DATA_WIDTH-1:0]   wbm_dat_next;
    logic                    wbm_ack_next;
    logic                    wbm_err_next;
    logic                    wbm_rty_next;
    logic [ADDR_WIDTH-1:0]   wbs_adr_next;
    logic [DATA_WIDTH-1:0]   wbs_dat_next;
    logic                    wbs_we_next;
    logic [SELECT_WIDTH-1:0] wbs_sel_next;
    logic                    wbs_stb_next;
    logic                    wbs_cyc_next;
    logic                    timeout_next;
    logic [COUNT_WIDTH-1:0]  timeout_count_next;

    logic request;
    logic slave_resp;
    logic expire;

    assign request    = wbm_cyc_i & wbm_stb_i & ~(wbm_ack_o | wbm_err_o | wbm_rty_o);
    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // The timer holds 1 during the last permitted strobe cycle.
    assign expire     = WATCHDOG_EN && (timer == TIMER_LAST);

    // Register state, timer and every output together; reset clears them all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            wbm_dat_o       <= '0;
            wbm_ack_o       <= 1'b0;
            wbm_err_o       <= 1'b0;
            wbm_rty_o       <= 1'b0;
            wbs_adr_o       <= '0;
            wbs_dat_o       <= '0;
            wbs_we_o        <= 1'b0;
            wbs_sel_o       <= '0;
            wbs_stb_o       <= 1'b0;
            wbs_cyc_o       <= 1'b0;
            timeout_o       <= 1'b0;
            timeout_count_o <= '0;
        end else begin
            state           <= state_next;
            timer           <= timer_next;
            wbm_dat_o       <= wbm_dat_next;
            wbm_ack_o       <= wbm_ack_next;
            wbm_err_o       <= wbm_err_next;
            wbm_rty_o       <= wbm_rty_next;
            wbs_adr_o       <= wbs_adr_next;
            wbs_dat_o       <= wbs_dat_next;
            wbs_we_o        <= wbs_we_next;
            wbs_sel_o       <= wbs_sel_next;
            wbs_stb_o       <= wbs_stb_next;
            wbs_cyc_o       <= wbs_cyc_next;
            timeout_o       <= timeout_next;
            timeout_count_o <= timeout_count_next;
        end
    end

    // Next-state decision; a master abort outranks a slave response or expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    state_next = IDLE;
                end else if (slave_resp || expire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next values of the output registers and the watchdog timer.
    always_comb begin
        // Captured transfer fields and read data hold; strobes and pulses clear.
        wbm_dat_next       = wbm_dat_o;
        wbm_ack_next       = 1'b0;
        wbm_err_next       = 1'b0;
        wbm_rty_next       = 1'b0;
        wbs_adr_next       = wbs_adr_o;
        wbs_dat_next       = wbs_dat_o;
        wbs_we_next        = wbs_we_o;
        wbs_sel_next       = wbs_sel_o;
        wbs_stb_next       = 1'b0;
        wbs_cyc_next       = 1'b0;
        timeout_next       = 1'b0;
        timeout_count_next = timeout_count_o;
        timer_next         = timer;
        case (state)
            IDLE: begin
                if (request) begin
                    wbs_adr_next = wbm_adr_i;
                    wbs_dat_next = wbm_dat_i;
                    wbs_we_next  = wbm_we_i;
                    wbs_sel_next = wbm_sel_i;
                    wbs_stb_next = 1'b1;
                    wbs_cyc_next = 1'b1;
                    timer_next   = TIMER_LOAD;
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    // Abort: a coincident slave response is discarded.
                    timer_next = '0;
                end else if (slave_resp) begin
                    // A response in the final timer cycle still wins.
                    wbm_dat_next = wbs_dat_i;
                    wbm_err_next = wbs_err_i;
                    wbm_rty_next = !wbs_err_i && wbs_rty_i;
                    wbm_ack_next = !wbs_err_i && !wbs_rty_i && wbs_ack_i;
                    timer_next   = '0;
                end else if (expire) begin
                    wbm_err_next = 1'b1;
                    timeout_next = 1'b1;
                    timer_next   = '0;
                    if (timeout_count_o != COUNT_MAX) begin
                        timeout_count_next = timeout_count_o + COUNT_ONE;
                    end
                end else begin
                    wbs_stb_next = 1'b1;
                    wbs_cyc_next = 1'b1;
                    if (WATCHDOG_EN) begin
                        timer_next = timer - TIMER_LAST;
                    end
                end
            end
            default: begin
                // RESP: the response registers clear through the defaults.
            end
        endcase
    end

endmodule

// File: tb/tb_wb_timeout_reg.sv
// Self-checking bench for wb_timeout_reg. Three instances share the master and
// slave stimulus: d0 (TIMEOUT=8) carries most scenarios, d1 (TIMEOUT=2,
// COUNT_WIDTH=2) covers counter saturation, d2 (TIMEOUT=0) covers the
// disabled watchdog. Only the instance a scenario targets is checked.
module tb_wb_timeout_reg;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int SW      = 4;
    localparam int TO_MAIN = 8;
    localparam int CW_MAIN = 16;
    localparam int TO_SAT  = 2;
    localparam int CW_SAT  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    logic          m_we;
    logic [SW-1:0] m_sel;
    logic          m_stb;
    logic          m_cyc;
    logic [DW-1:0] s_dat;
    logic          s_ack;
    logic          s_err;
    logic          s_rty;

    logic [DW-1:0] d0_dat, d1_dat, d2_dat;
    logic          d0_ack, d1_ack, d2_ack;
    logic          d0_err, d1_err, d2_err;
    logic          d0_rty, d1_rty, d2_rty;
    logic [AW-1:0] d0_sadr, d1_sadr, d2_sadr;
    logic [DW-1:0] d0_sdat, d1_sdat, d2_sdat;
    logic          d0_swe, d1_swe, d2_swe;
    logic [SW-1:0] d0_ssel, d1_ssel, d2_ssel;
    logic          d0_sstb, d1_sstb, d2_sstb;
    logic          d0_scyc, d1_scyc, d2_scyc;
    logic          d0_to, d1_to, d2_to;
    logic [CW_MAIN-1:0] d0_cnt;
    logic [CW_SAT-1:0]  d1_cnt;
    logic [CW_MAIN-1:0] d2_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_count = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 50000 cycles");
        $fatal(1, "global timeout");
    end

    wb_timeout_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                     .TIMEOUT(TO_MAIN), .COUNT_WIDTH(CW_MAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(d0_dat), .wbm_we_i(m_we),
        .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
        .wbm_ack_o(d0_ack), .wbm_err_o(d0_err), .wbm_rty_o(d0_rty),
        .wbs_adr_o(d0_sadr), .wbs_dat_o(d0_sdat), .wbs_dat_i(s_dat), .wbs_we_o(d0_swe),
        .wbs_sel_o(d0_ssel), .wbs_stb_o(d0_sstb), .wbs_cyc_o(d0_scyc),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .timeout_o(d0_to), .timeout_count_o(d0_cnt)
    );

    wb_timeout_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                     .TIMEOUT(TO_SAT), .COUNT_WIDTH(CW_SAT)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(d1_dat), .wbm_we_i(m_we),
        .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
        .wbm_ack_o(d1_ack), .wbm_err_o(d1_err), .wbm_rty_o(d1_rty),
        .wbs_adr_o(d1_sadr), .wbs_dat_o(d1_sdat), .wbs_dat_i(s_dat), .wbs_we_o(d1_swe),
        .wbs_sel_o(d1_ssel), .wbs_stb_o(d1_sstb), .wbs_cyc_o(d1_scyc),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .timeout_o(d1_to), .timeout_count_o(d1_cnt)
    );

    wb_timeout_reg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                     .TIMEOUT(0), .COUNT_WIDTH(CW_MAIN)) dut_inf (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(d2_dat), .wbm_we_i(m_we),
        .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc),
        .wbm_ack_o(d2_ack), .wbm_err_o(d2_err), .wbm_rty_o(d2_rty),
        .wbs_adr_o(d2_sadr), .wbs_dat_o(d2_sdat), .wbs_dat_i(s_dat), .wbs_we_o(d2_swe),
        .wbs_sel_o(d2_ssel), .wbs_stb_o(d2_sstb), .wbs_cyc_o(d2_scyc),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .timeout_o(d2_to), .timeout_count_o(d2_cnt)
    );

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic do_reset();
        rst_n = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_count = 0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // One transfer on d0. delay = strobe cycles the slave lets pass before
    // responding (0 = respond in the first strobe cycle), negative = silent.
    // resp = {err, rty, ack} driven by the slave.
    task automatic run_txn(input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                           input logic [DW-1:0] rdat, input logic we,
                           input logic [SW-1:0] sel, input int delay,
                           input logic [2:0] resp, input string name,
                           output int lat);
        int            exp_stb;
        logic          exp_to;
        logic [2:0]    exp_kind;
        logic [DW-1:0] exp_d;
        int            stb_cnt;
        logic          got;
        // reference model: response wins while within the TIMEOUT strobe cycles
        if (delay >= 0 && delay < TO_MAIN) begin
            exp_stb  = delay + 1;
            exp_to   = 1'b0;
            exp_kind = resp[2] ? 3'b100 : (resp[1] ? 3'b010 : 3'b001);
            exp_q.push_back(rdat);
        end else begin
            exp_stb  = TO_MAIN;
            exp_to   = 1'b1;
            exp_kind = 3'b100;
            if (mdl_count < (1 << CW_MAIN) - 1) mdl_count++;
        end
        m_adr = adr; m_dat = wdat; m_we = we; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
        stb_cnt = 0; got = 1'b0; lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            if (d0_ack || d0_err || d0_rty) begin
                got = 1'b1;
            end else if (d0_sstb) begin
                stb_cnt++;
                n_checks++;
                if ({d0_sadr, d0_sdat, d0_swe, d0_ssel, d0_scyc} !== {adr, wdat, we, sel, 1'b1}) begin
                    n_fail++;
                    $display("FAIL %s slave_fields: got adr=%h dat=%h we=%b sel=%h cyc=%b, want adr=%h dat=%h we=%b sel=%h cyc=1",
                             name, d0_sadr, d0_sdat, d0_swe, d0_ssel, d0_scyc, adr, wdat, we, sel);
                end
                if (stb_cnt == delay + 1) begin
                    {s_err, s_rty, s_ack} = resp;
                    s_dat = rdat;
                end
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s response_seen: got none within 60 cycles, want one", name);
        end
        n_checks++;
        if (lat != exp_stb + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_stb + 1);
        end
        n_checks++;
        if (stb_cnt != exp_stb) begin
            n_fail++;
            $display("FAIL %s stb_cycles: got %0d, want %0d", name, stb_cnt, exp_stb);
        end
        n_checks++;
        if ({d0_err, d0_rty, d0_ack} !== exp_kind) begin
            n_fail++;
            $display("FAIL %s resp_kind: got err/rty/ack=%b, want %b", name, {d0_err, d0_rty, d0_ack}, exp_kind);
        end
        n_checks++;
        if (d0_to !== exp_to) begin
            n_fail++;
            $display("FAIL %s timeout_pulse: got %b, want %b", name, d0_to, exp_to);
        end
        n_checks++;
        if (d0_cnt !== CW_MAIN'(mdl_count)) begin
            n_fail++;
            $display("FAIL %s timeout_count: got %0d, want %0d", name, d0_cnt, mdl_count);
        end
        n_checks++;
        if ({d0_sstb, d0_scyc} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s slave_dropped: got stb/cyc=%b, want 00", name, {d0_sstb, d0_scyc});
        end
        if (!exp_to) begin
            exp_d = exp_q.pop_front();
            n_checks++;
            if (d0_dat !== exp_d) begin
                n_fail++;
                $display("FAIL %s read_data: got %h, want %h", name, d0_dat, exp_d);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({d0_ack, d0_err, d0_rty, d0_to, d0_sstb} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s one_cycle_resp: got ack/err/rty/to/stb=%b, want 00000", name,
                     {d0_ack, d0_err, d0_rty, d0_to, d0_sstb});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ((|{d0_dat, d0_ack, d0_err, d0_rty, d0_sadr, d0_sdat, d0_swe, d0_ssel,
               d0_sstb, d0_scyc, d0_to, d0_cnt}) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_d0: got nonzero outputs (count=%0d stb=%b), want all 0", d0_cnt, d0_sstb);
        end
        n_checks++;
        if ((|{d1_dat, d1_ack, d1_err, d1_rty, d1_sadr, d1_sdat, d1_swe, d1_ssel,
               d1_sstb, d1_scyc, d1_to, d1_cnt}) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_d1: got nonzero outputs (count=%0d), want all 0", d1_cnt);
        end
        n_checks++;
        if ((|{d2_dat, d2_ack, d2_err, d2_rty, d2_sadr, d2_sdat, d2_swe, d2_ssel,
               d2_sstb, d2_scyc, d2_to, d2_cnt}) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_d2: got nonzero outputs (count=%0d), want all 0", d2_cnt);
        end
    endtask

    task automatic test_write();
        int lat;
        run_txn(32'h100, 32'hDEADBEEF, 32'h0, 1'b1, 4'hF, 1, 3'b001, "write", lat);
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL write_total_latency: got %0d, want 3", lat);
        end
    endtask

    task automatic test_read();
        int lat;
        run_txn(32'h104, 32'h0, 32'h12345678, 1'b0, 4'hF, 0, 3'b001, "read_ack", lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL read_min_latency: got %0d, want 2", lat);
        end
        run_txn(32'h108, 32'h0, 32'hCAFEF00D, 1'b0, 4'h3, 2, 3'b101, "read_err_ack", lat);
        run_txn(32'h10C, 32'h0, 32'h0BADC0DE, 1'b0, 4'hC, 1, 3'b011, "read_rty_ack", lat);
    endtask

    task automatic test_timeout();
        int lat;
        run_txn(32'h200, 32'h1, 32'h0, 1'b1, 4'hF, -1, 3'b000, "silent", lat);
        n_checks++;
        if (d0_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL timeout_count_one: got %0d, want 1", d0_cnt);
        end
        run_txn(32'h204, 32'h2, 32'h55555555, 1'b0, 4'hF, TO_MAIN - 1, 3'b001, "ack_last_cycle", lat);
    endtask

    task automatic test_abort();
        int stb_cnt;
        int lat;
        m_adr = 32'h300; m_dat = 32'h55AA; m_we = 1'b1; m_sel = 4'h3;
        m_cyc = 1'b1; m_stb = 1'b1;
        stb_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d0_sstb === 1'b1) stb_cnt++;
        end
        n_checks++;
        if (stb_cnt != 3) begin
            n_fail++;
            $display("FAIL abort_active: got %0d strobe cycles, want 3", stb_cnt);
        end
        // drop cyc with a coincident slave ack, which must be discarded
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b1; s_dat = 32'hBAD0BAD0;
        @(negedge clk);
        s_ack = 1'b0;
        n_checks++;
        if ({d0_scyc, d0_sstb, d0_ack, d0_err, d0_rty, d0_to} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_drop: got cyc/stb/ack/err/rty/to=%b, want 000000",
                     {d0_scyc, d0_sstb, d0_ack, d0_err, d0_rty, d0_to});
        end
        n_checks++;
        if (d0_cnt !== CW_MAIN'(mdl_count)) begin
            n_fail++;
            $display("FAIL abort_count: got %0d, want %0d", d0_cnt, mdl_count);
        end
        @(negedge clk);
        n_checks++;
        if ({d0_ack, d0_err, d0_rty} !== 3'b0) begin
            n_fail++;
            $display("FAIL abort_no_resp: got ack/err/rty=%b, want 000", {d0_ack, d0_err, d0_rty});
        end
        run_txn(32'h304, 32'h77, 32'h89ABCDEF, 1'b0, 4'hF, 2, 3'b001, "after_abort", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        int guard;
        guard = 0;
        while (mdl_count < 5 && guard < 10) begin
            run_txn($urandom, $urandom, 32'h0, 1'b1, 4'hF, -1, 3'b000, "fill_count", lat);
            guard++;
        end
        n_checks++;
        if (d0_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL count_before_reset: got %0d, want 5", d0_cnt);
        end
        m_adr = 32'h400; m_dat = 32'hA5A5A5A5; m_we = 1'b1; m_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((|{d0_dat, d0_ack, d0_err, d0_rty, d0_sadr, d0_sdat, d0_swe, d0_ssel,
               d0_sstb, d0_scyc, d0_to, d0_cnt}) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got stb=%b count=%0d adr=%h, want all outputs 0", d0_sstb, d0_cnt, d0_sadr);
        end
        rst_n = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
        mdl_count = 0;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if ({d0_ack, d0_err, d0_rty, d0_sstb} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: got ack/err/rty/stb=%b, want 0000", {d0_ack, d0_err, d0_rty, d0_sstb});
        end
        run_txn(32'h404, 32'h1234, 32'h600DF00D, 1'b0, 4'hF, 1, 3'b001, "after_reset", lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        // each transfer starts in the IDLE cycle right after the previous response
        run_txn(32'h500, 32'h11, 32'hAAAA0001, 1'b1, 4'h1, 0, 3'b001, "b2b_0", lat);
        run_txn(32'h504, 32'h22, 32'hAAAA0002, 1'b0, 4'h2, 0, 3'b010, "b2b_1", lat);
        run_txn(32'h508, 32'h33, 32'hAAAA0003, 1'b1, 4'h4, 0, 3'b100, "b2b_2", lat);
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 40; i++) begin
            run_txn($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 10)),
                    3'($urandom_range(1, 7)), "random", lat);
        end
    endtask

    task automatic test_saturate();
        int stb_cnt;
        int budget;
        logic got;
        int exp_cnt;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            m_adr = $urandom; m_dat = $urandom; m_we = 1'b1; m_sel = 4'hF;
            m_cyc = 1'b1; m_stb = 1'b1;
            stb_cnt = 0; got = 1'b0; budget = 0;
            while (!got && budget < 20) begin
                @(negedge clk);
                budget++;
                if (d1_ack || d1_err || d1_rty) got = 1'b1;
                else if (d1_sstb === 1'b1) stb_cnt++;
            end
            m_cyc = 1'b0; m_stb = 1'b0;
            exp_cnt = (k > 3) ? 3 : k;
            n_checks++;
            if (!got || stb_cnt != TO_SAT || {d1_err, d1_rty, d1_ack} !== 3'b100 || d1_to !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_expiry_%0d: got seen=%b stb=%0d err/rty/ack=%b to=%b, want 1 %0d 100 1",
                         k, got, stb_cnt, {d1_err, d1_rty, d1_ack}, d1_to, TO_SAT);
            end
            n_checks++;
            if (d1_cnt !== CW_SAT'(exp_cnt)) begin
                n_fail++;
                $display("FAIL sat_count_%0d: got %0d, want %0d", k, d1_cnt, exp_cnt);
            end
            @(negedge clk);
            n_checks++;
            if (d1_to !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_pulse_%0d: got timeout_o=%b one cycle later, want 0", k, d1_to);
            end
        end
    endtask

    task automatic test_no_watchdog();
        int bad;
        logic [DW-1:0] rdat;
        do_reset();
        m_adr = 32'h700; m_dat = 32'h0; m_we = 1'b0; m_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if ({d2_sstb, d2_scyc, d2_ack, d2_err, d2_rty, d2_to} !== 6'b110000) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nowd_wait: got %0d cycles not waiting, want 0", bad);
        end
        rdat = $urandom;
        s_ack = 1'b1; s_dat = rdat;
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        n_checks++;
        if ({d2_ack, d2_err, d2_rty, d2_to} !== 4'b1000 || d2_dat !== rdat || d2_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL nowd_ack: got ack/err/rty/to=%b dat=%h count=%0d, want 1000 %h 0",
                     {d2_ack, d2_err, d2_rty, d2_to}, d2_dat, d2_cnt, rdat);
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_saturate();
        test_no_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
